// File: rtl/soc_system_hex_pio_pkg.sv
// Shared constants for the HEX PIO: the register map, the 7-segment decode
// table and the blank pattern.
package soc_system_hex_pio_pkg;

  typedef enum logic [2:0] {
    ADDR_DATA      = 3'd0,
    ADDR_MODE      = 3'd1,
    ADDR_BLINK_EN  = 3'd2,
    ADDR_BLINK_DIV = 3'd3,
    ADDR_OUTSET    = 3'd4,
    ADDR_OUTCLEAR  = 3'd5,
    ADDR_STATUS    = 3'd6,
    ADDR_RSVD      = 3'd7
  } addr_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low gfedcba; entry n sits at index n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/soc_system_hex_seg_decode.sv
// Combinational hex nibble to active-low 7-segment decoder.
module soc_system_hex_seg_decode
  import soc_system_hex_pio_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/soc_system_hex_pio.sv
// Avalon-MM HEX display PIO: per-digit raw/hex-decode mode, atomic set/clear
// of the data bits and per-digit blinking driven by a programmable prescaler.
module soc_system_hex_pio
  import soc_system_hex_pio_pkg::*;
#(
  parameter int unsigned                      NUM_DIGITS = 2,
  parameter int unsigned                      SEG_W      = 8,
  parameter int unsigned                      DIV_W      = 24,
  parameter logic [DIV_W-1:0]                 DIV_RESET  = 24'd4_999_999,
  parameter logic [NUM_DIGITS*SEG_W-1:0]      DATA_RESET = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [2:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [NUM_DIGITS*SEG_W-1:0] out_port,
  output logic                        blink_phase
);

  localparam int unsigned DW = NUM_DIGITS * SEG_W;

  logic [DW-1:0]         data_r;
  logic [NUM_DIGITS-1:0] mode_r;
  logic [NUM_DIGITS-1:0] blink_en;
  logic [DIV_W-1:0]      blink_div;
  logic [DIV_W-1:0]      count;
  logic [DW-1:0]         digit_next;
  logic                  wr;
  addr_e                 addr_sel;
  logic                  unused_wd;

  assign wr        = chipselect & ~write_n;
  assign addr_sel  = addr_e'(address);
  assign unused_wd = ^writedata;

  always_ff @(posedge clk) begin
    if (reset) begin
      data_r      <= DATA_RESET;
      mode_r      <= '0;
      blink_en    <= '0;
      blink_div   <= DIV_RESET;
      count       <= DIV_RESET;
      blink_phase <= 1'b0;
      out_port    <= '1;
    end else begin
      if (wr) begin
        case (addr_sel)
          ADDR_DATA:      data_r    <= writedata[DW-1:0];
          ADDR_MODE:      mode_r    <= writedata[NUM_DIGITS-1:0];
          ADDR_BLINK_EN:  blink_en  <= writedata[NUM_DIGITS-1:0];
          ADDR_BLINK_DIV: blink_div <= writedata[DIV_W-1:0];
          ADDR_OUTSET:    data_r    <= data_r | writedata[DW-1:0];
          ADDR_OUTCLEAR:  data_r    <= data_r & ~writedata[DW-1:0];
          default: ;
        endcase
      end

      // A divider write restarts the count and swallows any toggle due now.
      if (wr && addr_sel == ADDR_BLINK_DIV) begin
        count <= writedata[DIV_W-1:0];
      end else if (count == '0) begin
        count       <= blink_div;
        blink_phase <= ~blink_phase;
      end else begin
        count <= count - DIV_W'(1);
      end

      out_port <= digit_next;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    logic [6:0]       seg;
    logic [SEG_W-1:0] raw;
    logic [SEG_W-1:0] dec_word;
    logic [SEG_W-1:0] blank_word;

    soc_system_hex_seg_decode u_dec (
      .nibble (data_r[i*SEG_W +: 4]),
      .seg    (seg)
    );

    assign raw = data_r[i*SEG_W +: SEG_W];

    if (SEG_W > 7) begin : g_dp
      assign dec_word   = {{(SEG_W-7){1'b1}}, seg};
      assign blank_word = {{(SEG_W-7){1'b1}}, SEG_BLANK};
    end else begin : g_nodp
      assign dec_word   = seg;
      assign blank_word = SEG_BLANK;
    end

    assign digit_next[i*SEG_W +: SEG_W] = (blink_en[i] && blink_phase) ? blank_word :
                                          mode_r[i]                   ? dec_word   : raw;
  end

  always_comb begin
    readdata = '0;
    case (addr_sel)
      ADDR_DATA:      readdata[DW-1:0]         = data_r;
      ADDR_MODE:      readdata[NUM_DIGITS-1:0] = mode_r;
      ADDR_BLINK_EN:  readdata[NUM_DIGITS-1:0] = blink_en;
      ADDR_BLINK_DIV: readdata[DIV_W-1:0]      = blink_div;
      ADDR_STATUS:    readdata[0]              = blink_phase;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_soc_system_hex_pio.sv
// Self-checking bench for soc_system_hex_pio (2 digits x 8 bits).
module tb_soc_system_hex_pio;

  localparam logic [23:0] DIV_RST = 24'd4_999_999;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        chipselect = 1'b0;
  logic        write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic [15:0] out_port;
  logic        blink_phase;

  int errors = 0;
  int checks = 0;

  soc_system_hex_pio #(
    .NUM_DIGITS (2),
    .SEG_W      (8),
    .DIV_W      (24),
    .DIV_RESET  (DIV_RST),
    .DATA_RESET (16'hFFFF)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .chipselect  (chipselect),
    .write_n     (write_n),
    .writedata   (writedata),
    .readdata    (readdata),
    .out_port    (out_port),
    .blink_phase (blink_phase)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [6:0]  dec_tab [16];
  logic [15:0] m_data;
  logic [1:0]  m_mode;
  logic [1:0]  m_ben;
  logic [23:0] m_div;
  logic [23:0] m_cnt;
  logic        m_phase;
  logic [15:0] m_out;

  task automatic model_reset();
    m_data  = 16'hFFFF;
    m_mode  = '0;
    m_ben   = '0;
    m_div   = DIV_RST;
    m_cnt   = DIV_RST;
    m_phase = 1'b0;
    m_out   = 16'hFFFF;
  endtask

  function automatic logic [15:0] model_digits();
    logic [15:0] r;
    logic [7:0]  f;
    r = '0;
    for (int unsigned d = 0; d < 2; d++) begin
      f = m_data[d*8 +: 8];
      if (m_ben[d] && m_phase) r[d*8 +: 8] = 8'hFF;
      else if (m_mode[d])      r[d*8 +: 8] = {1'b1, dec_tab[f[3:0]]};
      else                     r[d*8 +: 8] = f;
    end
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {16'h0, m_data};
      3'd1:    return {30'h0, m_mode};
      3'd2:    return {30'h0, m_ben};
      3'd3:    return {8'h0, m_div};
      3'd6:    return {31'h0, m_phase};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic w, input logic [2:0] a, input logic [31:0] wd);
    logic [15:0] nout;
    if (reset) begin
      model_reset();
      return;
    end
    nout = model_digits();
    if (w && a == 3'd3) m_cnt = wd[23:0];
    else if (m_cnt == 0) begin
      m_cnt   = m_div;
      m_phase = ~m_phase;
    end else m_cnt = m_cnt - 24'd1;
    if (w) begin
      case (a)
        3'd0: m_data = wd[15:0];
        3'd1: m_mode = wd[1:0];
        3'd2: m_ben  = wd[1:0];
        3'd3: m_div  = wd[23:0];
        3'd4: m_data = m_data | wd[15:0];
        3'd5: m_data = m_data & ~wd[15:0];
        default: ;
      endcase
    end
    m_out = nout;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus cycle, advance one edge, settle to 1 time unit past it.
  task automatic step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    @(posedge clk);
    model_edge(cs && !wn, a, wd);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
    address    = '0;
    writedata  = '0;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 3'd0, 32'h0);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd);
    step(1'b1, 1'b0, a, wd);
  endtask

  task automatic check_read(input string name, input logic [2:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, readdata, exp);
  endtask

  typedef struct {
    logic [15:0] data;
    logic [1:0]  mode;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [2:0]  ra;
    logic [2:0]  a;
    logic        cs;
    logic        wn;
    logic [31:0] wd;

    dec_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs = '{
      '{16'h0100, 2'b11, 16'hF9C0},
      '{16'h0302, 2'b11, 16'hB0A4},
      '{16'h0504, 2'b11, 16'h9299},
      '{16'h0706, 2'b11, 16'hF882},
      '{16'h0908, 2'b11, 16'h9080},
      '{16'h0B0A, 2'b11, 16'h8388},
      '{16'h0D0C, 2'b11, 16'hA1C6},
      '{16'h0F0E, 2'b11, 16'h8E86},
      '{16'h5A3C, 2'b00, 16'h5A3C},
      '{16'h1234, 2'b01, 16'h1299},
      '{16'hF7E3, 2'b10, 16'hF8E3}
    };
    model_reset();

    // Reset state
    reset = 1'b1;
    idle();
    idle();
    reset = 1'b0;
    check("reset_out_port", {16'h0, out_port}, 32'h0000FFFF);
    check("reset_phase", {31'h0, blink_phase}, 32'h0);
    for (int unsigned i = 0; i < 8; i++) begin
      ra = 3'(i);
      check_read($sformatf("reset_read_%0d", i), ra,
                 (i == 0) ? 32'h0000FFFF : (i == 3) ? 32'h004C4B3F : 32'h0);
    end

    // Decode with one-cycle output latency
    wr_reg(3'd1, 32'h3);
    wr_reg(3'd0, 32'h0A05);
    check("decode_latency_old", {16'h0, out_port}, 32'h00008E8E);
    check_read("data_readback", 3'd0, 32'h00000A05);
    idle();
    check("decode_0a05", {16'h0, out_port}, 32'h00008892);

    // Table-driven digit function
    foreach (vecs[i]) begin
      wr_reg(3'd1, {30'h0, vecs[i].mode});
      wr_reg(3'd0, {16'h0, vecs[i].data});
      idle();
      check($sformatf("digit_vec_%0d", i), {16'h0, out_port}, {16'h0, vecs[i].exp_out});
    end

    // Atomic set / clear, ignored writes
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd0, 32'h00FF);
    wr_reg(3'd4, 32'h0100);
    wr_reg(3'd5, 32'h000F);
    check_read("setclr_data", 3'd0, 32'h000001F0);
    step(1'b0, 1'b0, 3'd0, 32'h1234);
    check_read("cs_low_ignored", 3'd0, 32'h000001F0);
    wr_reg(3'd6, 32'hFFFF_FFFF);
    check_read("outset_reads0", 3'd4, 32'h0);
    check_read("outclr_reads0", 3'd5, 32'h0);
    check_read("status_ro", 3'd6, 32'h0);

    // Blink with BLINK_DIV=3: toggle every 4 edges, out_port lags one edge
    wr_reg(3'd3, 32'd3);
    wr_reg(3'd2, 32'h1);
    wr_reg(3'd1, 32'h0);
    wr_reg(3'd0, 32'h0);
    for (int unsigned k = 4; k < 20; k++) begin
      idle();
      check($sformatf("blink_phase_k%0d", k), {31'h0, blink_phase}, 32'((k / 4) % 2));
      check($sformatf("blink_out_k%0d", k), {16'h0, out_port},
            (((k - 1) / 4) % 2 == 1) ? 32'h00FF : 32'h0000);
    end

    // Divider write exactly when the counter reaches zero
    wr_reg(3'd3, 32'd5);
    check("div_write_no_toggle", {31'h0, blink_phase}, 32'h0);
    for (int unsigned j = 1; j <= 6; j++) begin
      idle();
      check($sformatf("div5_phase_j%0d", j), {31'h0, blink_phase}, (j == 6) ? 32'h1 : 32'h0);
    end

    // Clearing BLINK_EN while blanked
    idle();
    check("blanked_digit0", {16'h0, out_port}, 32'h00FF);
    wr_reg(3'd2, 32'h0);
    check("unblank_lag", {16'h0, out_port}, 32'h00FF);
    idle();
    check("unblanked", {16'h0, out_port}, 32'h0000);
    check("phase_still_1", {31'h0, blink_phase}, 32'h1);

    // Reset mid-blink
    wr_reg(3'd0, 32'h1234);
    wr_reg(3'd2, 32'h3);
    idle();
    idle();
    reset = 1'b1;
    idle();
    check("midreset_out", {16'h0, out_port}, 32'h0000FFFF);
    check("midreset_phase", {31'h0, blink_phase}, 32'h0);
    check_read("midreset_data", 3'd0, 32'h0000FFFF);
    check_read("midreset_div", 3'd3, 32'h004C4B3F);
    reset = 1'b0;

    // Randomized traffic against the reference model
    wr_reg(3'd3, 32'($urandom_range(0, 5)));
    for (int unsigned n = 0; n < 400; n++) begin
      a  = 3'($urandom_range(0, 7));
      cs = ($urandom_range(0, 3) != 0);
      wn = 1'($urandom_range(0, 1));
      wd = $urandom;
      if (a == 3'd3) wd = 32'($urandom_range(0, 6));
      if ($urandom_range(0, 99) == 0) reset = 1'b1;
      step(cs, wn, a, wd);
      reset = 1'b0;
      check($sformatf("rand_out_%0d", n), {16'h0, out_port}, {16'h0, m_out});
      check($sformatf("rand_phase_%0d", n), {31'h0, blink_phase}, {31'h0, m_phase});
      ra = 3'($urandom_range(0, 7));
      check_read($sformatf("rand_read_%0d_a%0d", n, ra), ra, model_read(ra));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
